// File: rtl/dense_pkg.sv
// Shared types and elaboration-time width helpers for the dense dot-product engine.
// Latency: none (package only).
// Backpressure: not applicable.
package dense_pkg;

    // Engine run state: armed by start, drained after the last beat.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Tag bit positions carried alongside data through the pipe.
    localparam int TAG_FIRST = 0;
    localparam int TAG_LAST  = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    // Width of the adder-tree sum for `lanes` products of two dw-bit operands.
    function automatic int tree_w(input int dw, input int lanes);
        return 2 * dw + clog2(lanes);
    endfunction

    // Accumulator width: tree sum plus growth for chunk accumulation (at least one guard bit).
    function automatic int acc_w(input int dw, input int lanes, input int chunks);
        return tree_w(dw, lanes) + clog2(chunks) + ((chunks == 1) ? 1 : 0);
    endfunction

    // Number of nodes at tree level l for n leaves: ceil(n / 2^l).
    function automatic int lvl_cnt(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: sums N packed W-bit lanes into one W+clog2(N)-bit result.
// Latency: clog2(N) cycles of i_en; one register per level, odd leftovers ride through.
// Backpressure: i_en freezes every level and the valid/tag pipe together.
module adder_tree_pipe
    import dense_pkg::*;
#(
    parameter int N    = 25,
    parameter int W    = 32,
    parameter int TAGW = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic                         i_vld,
    input  logic [TAGW-1:0]              i_tag,
    input  logic [N*W-1:0]               i_dat,
    output logic                         o_vld,
    output logic [TAGW-1:0]              o_tag,
    output logic signed [W+clog2(N)-1:0] o_sum
);

    localparam int T  = clog2(N);
    localparam int SW = W + T;

    // Node values per level; level 0 is the sign-extended input, level T node 0 is the sum.
    logic signed [SW-1:0] w_node [T+1][N];
    logic [T-1:0]         r_vld;
    logic [TAGW-1:0]      r_tag [T];

    for (genvar j = 0; j < N; j++) begin : g_in
        assign w_node[0][j] = {{T{i_dat[j*W+W-1]}}, i_dat[j*W +: W]};
    end

    for (genvar l = 1; l <= T; l++) begin : g_lvl
        localparam int NP = lvl_cnt(N, l - 1);
        localparam int NC = lvl_cnt(N, l);
        for (genvar j = 0; j < N; j++) begin : g_node
            if (j >= NC) begin : g_unused
                assign w_node[l][j] = '0;
            end else if (2 * j + 1 < NP) begin : g_add
                logic signed [SW-1:0] r_sum;
                // Pairwise add of the two children from the level below.
                always_ff @(posedge clk) begin
                    if (i_en) r_sum <= w_node[l-1][2*j] + w_node[l-1][2*j+1];
                end
                assign w_node[l][j] = r_sum;
            end else begin : g_pass
                logic signed [SW-1:0] r_pass;
                // Odd leftover element is registered unchanged to stay aligned.
                always_ff @(posedge clk) begin
                    if (i_en) r_pass <= w_node[l-1][2*j];
                end
                assign w_node[l][j] = r_pass;
            end
        end
    end

    // Valid and tag shift alongside the data, one stage per tree level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < T; k++) r_tag[k] <= '0;
        end else if (i_en) begin
            r_vld[0] <= i_vld;
            r_tag[0] <= i_tag;
            for (int k = 1; k < T; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign o_vld = r_vld[T-1];
    assign o_tag = r_tag[T-1];
    assign o_sum = w_node[T][0];

endmodule

// File: rtl/dense_dotprod_engine.sv
// Streaming dense dot-product: lane multiply, pipelined tree, chunk accumulate, rescale/ReLU/saturate.
// Latency: last-chunk handshake at cycle t gives out_v at t+clog2(LANES)+3.
// Backpressure: a held output (out_v && !out_rdy) freezes the whole pipe and drops in_rdy.
module dense_dotprod_engine
    import dense_pkg::*;
#(
    parameter int LANES   = 25,
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int CHUNKS  = 4,
    parameter int OUTPUTS = 16,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_v,
    output logic                in_rdy,
    input  logic [LANES*DW-1:0] in_fea,
    input  logic [LANES*DW-1:0] in_wgt,
    output logic                out_v,
    input  logic                out_rdy,
    output logic [DW-1:0]       out_data,
    output logic                busy,
    output logic                done,
    output logic                sat
);

    localparam int PW   = 2 * DW;
    localparam int SW   = tree_w(DW, LANES);
    localparam int ACCW = acc_w(DW, LANES, CHUNKS);
    localparam int CW   = cnt_w(CHUNKS);
    localparam int OW   = cnt_w(OUTPUTS);
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                 r_state;
    logic [CW-1:0]          r_chunk;
    logic [OW-1:0]          r_in_idx;
    logic [OW-1:0]          r_out_idx;
    logic                   w_en;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_first;
    logic                   w_last;
    logic                   w_arm;
    logic [LANES*PW-1:0]    w_prod;
    logic [LANES*PW-1:0]    r_prod;
    logic                   r_m_vld;
    logic [1:0]             r_m_tag;
    logic                   w_t_vld;
    logic [1:0]             w_t_tag;
    logic signed [SW-1:0]   w_t_sum;
    logic signed [ACCW-1:0] w_ext;
    logic signed [ACCW-1:0] r_acc;
    logic                   r_acc_vld;
    logic signed [ACCW-1:0] w_shr;
    logic [DW-1:0]          w_res;
    logic                   w_clip;
    logic                   r_out_v;
    logic [DW-1:0]          r_out_data;
    logic                   r_sat;

    assign w_en     = !(r_out_v && !out_rdy);
    assign in_rdy   = w_en && (r_state == ST_RUN);
    assign w_in_hs  = in_v && in_rdy;
    assign w_out_hs = r_out_v && out_rdy;
    assign w_first  = (r_chunk == '0);
    assign w_last   = (r_chunk == CW'(CHUNKS - 1));
    assign w_arm    = (r_state == ST_IDLE) && start;

    // Run control: beat/chunk counters on the input side, output counter on the result side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_chunk   <= '0;
            r_in_idx  <= '0;
            r_out_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_chunk   <= '0;
                        r_in_idx  <= '0;
                        r_out_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_in_hs && w_last && (r_in_idx == OW'(OUTPUTS - 1))) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_out_hs && (r_out_idx == OW'(OUTPUTS - 1))) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_in_hs) begin
                if (w_last) begin
                    r_chunk  <= '0;
                    r_in_idx <= r_in_idx + OW'(1);
                end else begin
                    r_chunk <= r_chunk + CW'(1);
                end
            end
            if (w_out_hs) r_out_idx <= r_out_idx + OW'(1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_mul
        logic signed [PW-1:0] w_f;
        logic signed [PW-1:0] w_w;
        logic signed [PW-1:0] w_p;
        assign w_f = {{DW{in_fea[i*DW+DW-1]}}, in_fea[i*DW +: DW]};
        assign w_w = {{DW{in_wgt[i*DW+DW-1]}}, in_wgt[i*DW +: DW]};
        assign w_p = w_f * w_w;
        assign w_prod[i*PW +: PW] = w_p;
    end

    // Stage M: register lane products; bubbles become invalid tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_vld <= 1'b0;
            r_m_tag <= '0;
        end else if (w_en) begin
            r_m_vld <= w_in_hs;
            r_m_tag <= {w_last, w_first};
        end
    end

    // Product data needs no reset; its valid tag qualifies it.
    always_ff @(posedge clk) begin
        if (w_en) r_prod <= w_prod;
    end

    adder_tree_pipe #(
        .N    (LANES),
        .W    (PW),
        .TAGW (2)
    ) u_tree (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_vld (r_m_vld),
        .i_tag (r_m_tag),
        .i_dat (r_prod),
        .o_vld (w_t_vld),
        .o_tag (w_t_tag),
        .o_sum (w_t_sum)
    );

    assign w_ext = {{(ACCW-SW){w_t_sum[SW-1]}}, w_t_sum};

    // Chunk accumulation: first chunk loads, later chunks add, bubbles hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_acc_vld <= 1'b0;
        end else if (w_arm) begin
            r_acc     <= '0;
            r_acc_vld <= 1'b0;
        end else if (w_en) begin
            r_acc_vld <= w_t_vld && w_t_tag[TAG_LAST];
            if (w_t_vld) r_acc <= w_t_tag[TAG_FIRST] ? w_ext : (r_acc + w_ext);
        end
    end

    // Rescale by FRAC, optional ReLU, then clamp into the signed DW-bit range.
    always_comb begin
        w_shr  = r_acc >>> FRAC;
        w_res  = w_shr[DW-1:0];
        w_clip = 1'b0;
        if (RELU_EN && w_shr[ACCW-1]) begin
            w_res = '0;
        end else if (w_shr > MAXV) begin
            w_res  = MAXV[DW-1:0];
            w_clip = 1'b1;
        end else if (w_shr < MINV) begin
            w_res  = MINV[DW-1:0];
            w_clip = 1'b1;
        end
    end

    // Output register reloads whenever the pipe advances, so a handshake and new result overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v    <= 1'b0;
            r_out_data <= '0;
            r_sat      <= 1'b0;
        end else begin
            if (w_arm)                           r_sat <= 1'b0;
            else if (w_en && r_acc_vld && w_clip) r_sat <= 1'b1;
            if (w_en) begin
                r_out_v <= r_acc_vld;
                if (r_acc_vld) r_out_data <= w_res;
            end
        end
    end

    assign out_v    = r_out_v;
    assign out_data = r_out_data;
    assign sat      = r_sat;
    assign busy     = (r_state != ST_IDLE);
    assign done     = w_out_hs && (r_state == ST_DRAIN) && (r_out_idx == OW'(OUTPUTS - 1));

endmodule

// File: tb/tb_dense_dotprod_engine.sv
// Directed bench for dense_dotprod_engine: two instances (ReLU on / off) share one stimulus.
// Latency: checks first-output latency of 8 cycles after the last-chunk handshake.
// Backpressure: holds out_rdy low mid-run and checks freeze and output integrity.
module tb_dense_dotprod_engine;

    localparam int LANES   = 25;
    localparam int DW      = 16;
    localparam int FRAC    = 8;
    localparam int CHUNKS  = 4;
    localparam int OUTPUTS = 16;
    localparam int NBEATS  = OUTPUTS * CHUNKS;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_v;
    logic                out_rdy;
    logic [LANES*DW-1:0] in_fea;
    logic [LANES*DW-1:0] in_wgt;
    logic                in_rdy_a, out_v_a, busy_a, done_a, sat_a;
    logic [DW-1:0]       out_data_a;
    logic                in_rdy_b, out_v_b, busy_b, done_b, sat_b;
    logic [DW-1:0]       out_data_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_cnt  = 0;
    int first_cyc = -1;
    int last_hs_cyc = 0;
    int tmo = 0;

    logic [DW-1:0]       q_a[$];
    logic [DW-1:0]       q_b[$];
    logic [LANES*DW-1:0] fea_mem [NBEATS];
    logic [LANES*DW-1:0] wgt_mem [NBEATS];
    logic [DW-1:0]       exp_a [OUTPUTS];
    logic [DW-1:0]       exp_b [OUTPUTS];

    dense_dotprod_engine #(
        .LANES(LANES), .DW(DW), .FRAC(FRAC), .CHUNKS(CHUNKS), .OUTPUTS(OUTPUTS), .RELU_EN(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_v(in_v), .in_rdy(in_rdy_a),
        .in_fea(in_fea), .in_wgt(in_wgt), .out_v(out_v_a), .out_rdy(out_rdy),
        .out_data(out_data_a), .busy(busy_a), .done(done_a), .sat(sat_a)
    );

    dense_dotprod_engine #(
        .LANES(LANES), .DW(DW), .FRAC(FRAC), .CHUNKS(CHUNKS), .OUTPUTS(OUTPUTS), .RELU_EN(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_v(in_v), .in_rdy(in_rdy_b),
        .in_fea(in_fea), .in_wgt(in_wgt), .out_v(out_v_b), .out_rdy(out_rdy),
        .out_data(out_data_b), .busy(busy_b), .done(done_b), .sat(sat_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Output monitor samples late in the low phase, after the driver has settled.
    always begin
        @(negedge clk);
        #2;
        if (out_v_a && out_rdy) q_a.push_back(out_data_a);
        if (out_v_b && out_rdy) q_b.push_back(out_data_b);
        if (done_a) done_cnt = done_cnt + 1;
        if (out_v_a && first_cyc < 0) first_cyc = cyc;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] model(input longint acc, input bit relu);
        longint r;
        r = acc >>> FRAC;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[DW-1:0];
    endfunction

    task automatic fill_const(input logic [DW-1:0] f, input logic [DW-1:0] w);
        for (int b = 0; b < NBEATS; b++)
            for (int i = 0; i < LANES; i++) begin
                fea_mem[b][i*DW +: DW] = f;
                wgt_mem[b][i*DW +: DW] = w;
            end
    endtask

    task automatic fill_random();
        int x;
        int y;
        for (int b = 0; b < NBEATS; b++)
            for (int i = 0; i < LANES; i++) begin
                x = $urandom_range(0, 600) - 300;
                y = $urandom_range(0, 600) - 300;
                fea_mem[b][i*DW +: DW] = x[DW-1:0];
                wgt_mem[b][i*DW +: DW] = y[DW-1:0];
            end
    endtask

    task automatic model_expect();
        longint acc;
        logic signed [DW-1:0] fa;
        logic signed [DW-1:0] wa;
        for (int o = 0; o < OUTPUTS; o++) begin
            acc = 0;
            for (int c = 0; c < CHUNKS; c++)
                for (int i = 0; i < LANES; i++) begin
                    fa = fea_mem[o*CHUNKS+c][i*DW +: DW];
                    wa = wgt_mem[o*CHUNKS+c][i*DW +: DW];
                    acc += longint'(fa) * longint'(wa);
                end
            exp_a[o] = model(acc, 1'b1);
            exp_b[o] = model(acc, 1'b0);
        end
    endtask

    task automatic set_expect(input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        for (int o = 0; o < OUTPUTS; o++) begin
            exp_a[o] = ea;
            exp_b[o] = eb;
        end
    endtask

    // Entered at a falling edge; returns at a falling edge after the beat is accepted.
    task automatic send_beat(input logic [LANES*DW-1:0] f, input logic [LANES*DW-1:0] w);
        bit hs;
        bit ok;
        int now;
        ok = 1'b0;
        in_v = 1'b1;
        in_fea = f;
        in_wgt = w;
        for (int n = 0; n < 200; n++) begin
            #1;
            hs = in_rdy_a;
            now = cyc;
            @(negedge clk);
            start = 1'b0;
            if (hs) begin
                ok = 1'b1;
                last_hs_cyc = now;
                break;
            end
        end
        in_v = 1'b0;
        if (!ok) tmo++;
    endtask

    task automatic run_beats(input int lo, input int hi, input bit gaps, output int lat_hs);
        lat_hs = -1;
        for (int b = lo; b < hi; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
            send_beat(fea_mem[b], wgt_mem[b]);
            if (b == CHUNKS - 1) lat_hs = last_hs_cyc;
        end
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, (done_cnt != d0), 1);
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cnt_a"}, q_a.size(), OUTPUTS);
        check({tag, "_cnt_b"}, q_b.size(), OUTPUTS);
        for (int o = 0; o < OUTPUTS && o < q_a.size(); o++)
            check($sformatf("%s_a[%0d]", tag, o), q_a[o], exp_a[o]);
        for (int o = 0; o < OUTPUTS && o < q_b.size(); o++)
            check($sformatf("%s_b[%0d]", tag, o), q_b[o], exp_b[o]);
    endtask

    task automatic arm_run();
        q_a.delete();
        q_b.delete();
        done_cnt = 0;
        first_cyc = -1;
        tmo = 0;
        start = 1'b1;
        #1;
        check("rdy_in_start_cycle", in_rdy_a, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_start", busy_a, 1);
        check("rdy_after_start", in_rdy_a, 1);
        @(negedge clk);
    endtask

    initial begin
        int lat_hs;
        int dummy;
        int n;
        logic [DW-1:0] hold_val;
        bit stable;
        bit rdy_seen;

        rst = 1'b1;
        start = 1'b0;
        in_v = 1'b0;
        out_rdy = 1'b1;
        in_fea = '0;
        in_wgt = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_rdy", in_rdy_a, 0);
        check("rst_out_v", out_v_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_sat", sat_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_out_v_b", out_v_b, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: all 1.0 operands, one stray start mid-run, latency measured with no stalls.
        fill_const(16'h0100, 16'h0100);
        set_expect(16'd25600, 16'd25600);
        arm_run();
        run_beats(0, 10, 1'b0, lat_hs);
        start = 1'b1;
        run_beats(10, NBEATS, 1'b0, dummy);
        check("r1_beat_timeout", tmo, 0);
        wait_done("r1_done_seen");
        check_outputs("r1");
        check("r1_done_cnt", done_cnt, 1);
        check("r1_sat", sat_a, 0);
        check("r1_busy_idle", busy_a, 0);
        check("r1_latency", first_cyc - lat_hs, 8);

        // Run 2: negative weights; ReLU instance gives 0, linear instance -25600.
        fill_const(16'h0100, 16'hFF00);
        set_expect(16'h0000, 16'h9C00);
        arm_run();
        run_beats(0, NBEATS, 1'b0, dummy);
        check("r2_beat_timeout", tmo, 0);
        wait_done("r2_done_seen");
        check_outputs("r2");
        check("r2_sat_a", sat_a, 0);
        check("r2_sat_b", sat_b, 0);

        // Run 3: full-scale operands saturate positive.
        fill_const(16'h7FFF, 16'h7FFF);
        set_expect(16'h7FFF, 16'h7FFF);
        arm_run();
        run_beats(0, NBEATS, 1'b0, dummy);
        check("r3_beat_timeout", tmo, 0);
        wait_done("r3_done_seen");
        check_outputs("r3");
        check("r3_sat_a", sat_a, 1);
        check("r3_sat_b", sat_b, 1);
        repeat (3) @(negedge clk);
        check("r3_sat_sticky", sat_a, 1);

        // Run 4: random operands with input gaps and a 10-cycle output stall.
        fill_random();
        model_expect();
        arm_run();
        check("r4_sat_cleared", sat_a, 0);
        run_beats(0, 24, 1'b1, dummy);
        #1;
        n = 0;
        while (!out_v_a && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("r4_out_v_before_stall", out_v_a, 1);
        out_rdy = 1'b0;
        #1;
        check("r4_rdy_drops", in_rdy_a, 0);
        hold_val = out_data_a;
        stable = 1'b1;
        rdy_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (!out_v_a || out_data_a !== hold_val) stable = 1'b0;
            if (in_rdy_a) rdy_seen = 1'b1;
        end
        check("r4_stall_data_stable", stable, 1);
        check("r4_stall_rdy_low", rdy_seen, 0);
        out_rdy = 1'b1;
        @(negedge clk);
        run_beats(24, NBEATS, 1'b1, dummy);
        check("r4_beat_timeout", tmo, 0);
        wait_done("r4_done_seen");
        check_outputs("r4");
        check("r4_done_cnt", done_cnt, 1);

        // Run 5: reset after 30 beats aborts the run with no later output.
        fill_const(16'h0100, 16'h0100);
        arm_run();
        run_beats(0, 30, 1'b0, dummy);
        check("r5_partial_out", (q_a.size() > 0), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("r5_out_v", out_v_a, 0);
        check("r5_in_rdy", in_rdy_a, 0);
        check("r5_busy", busy_a, 0);
        check("r5_out_data", out_data_a, 0);
        check("r5_done", done_a, 0);
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("r5_no_late_output", q_a.size(), 0);
        check("r5_no_done", done_cnt, 0);
        check("r5_still_idle", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
